// File: rtl/window_buffer_kxk.sv
// rtl/window_buffer_kxk.sv - KxK sliding-window generator over a multi-transfer raster stream; optional stride 2 under WINDOW_STRIDE2_EN
module window_buffer_kxk #(
  parameter int WORD_WIDTH     = 8,
  parameter int KERNEL         = 3,
  parameter int MAX_IMG_WIDTH  = 128,
  parameter int MAX_IMG_HEIGHT = 128,
  parameter int MAX_TRANSFERS  = 512
) (
  input  logic                                   i_clk,
  input  logic                                   i_reset_n,
  input  logic                                   i_load_param,
  input  logic [$clog2(MAX_IMG_WIDTH):0]         i_width,
  input  logic [$clog2(MAX_IMG_HEIGHT):0]        i_height,
  input  logic [$clog2(MAX_TRANSFERS):0]         i_transfers,
  input  logic                                   i_stride,
  input  logic                                   i_valid,
  output logic                                   o_ready,
  input  logic [WORD_WIDTH-1:0]                  i_data,
  output logic                                   o_valid,
  input  logic                                   i_ready,
  output logic [KERNEL*KERNEL*WORD_WIDTH-1:0]    o_window,
  output logic                                   o_last_window
);

  localparam int XW    = $clog2(MAX_IMG_WIDTH) + 1;
  localparam int YW    = $clog2(MAX_IMG_HEIGHT) + 1;
  localparam int TW    = $clog2(MAX_TRANSFERS) + 1;
  localparam int DEPTH = MAX_IMG_WIDTH * MAX_TRANSFERS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TIW   = (MAX_TRANSFERS > 1) ? $clog2(MAX_TRANSFERS) : 1;
  localparam int COLW  = KERNEL * WORD_WIDTH;
  localparam int WINW  = KERNEL * COLW;

  if ((KERNEL % 2) == 0 || KERNEL < 3 || KERNEL > 7) begin : g_bad_kernel
    $error("window_buffer_kxk: KERNEL must be odd and within 3..7");
  end

  // geometry
  logic [XW-1:0] r_width;
  logic [YW-1:0] r_height;
  logic [TW-1:0] r_trans;
  logic [XW-1:0] r_last_x;
  logic [YW-1:0] r_last_y;

  // raster position of the next word; r_addr = x*T + t within the current row
  logic [TW-1:0] r_t;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [AW-1:0] r_addr;

  // r_line[k] holds row y-1-k; r_hist[j][t] holds the column vector of pixel x-1-j at transfer t
  logic [WORD_WIDTH-1:0] r_line [KERNEL-1][2**AW];
  logic [COLW-1:0]       r_hist [KERNEL-1][2**TIW];

  logic                  r_valid;
  logic [WINW-1:0]       r_window;
  logic                  r_last;

  logic                  w_accept;
  logic                  w_param_ok;
  logic                  w_t_wrap;
  logic                  w_x_wrap;
  logic                  w_y_wrap;
  logic                  w_phase_ok;
  logic                  w_emit;
  logic                  w_is_last;
  logic [TIW-1:0]        w_t_idx;
  logic [XW-1:0]         w_new_last_x;
  logic [YW-1:0]         w_new_last_y;
  logic [COLW-1:0]       w_col;
  logic [WINW-1:0]       w_win;

`ifdef WINDOW_STRIDE2_EN
  logic r_stride;
  // with K odd, (pos-K+1) is even exactly when pos is even
  assign w_phase_ok = !r_stride || (!r_x[0] && !r_y[0]);
`else
  logic w_unused_stride;
  assign w_unused_stride = i_stride;
  assign w_phase_ok      = 1'b1;
`endif

  assign o_ready       = !i_load_param && (!r_valid || i_ready);
  assign w_accept      = i_valid && o_ready;
  assign o_valid       = r_valid;
  assign o_window      = r_window;
  assign o_last_window = r_last;

  assign w_param_ok = (i_width >= XW'(KERNEL)) && (i_width <= XW'(MAX_IMG_WIDTH)) &&
                      (i_height >= YW'(KERNEL)) && (i_height <= YW'(MAX_IMG_HEIGHT)) &&
                      (i_transfers != '0) && (i_transfers <= TW'(MAX_TRANSFERS));

  assign w_t_wrap  = (r_t == r_trans - TW'(1));
  assign w_x_wrap  = (r_x == r_width - XW'(1));
  assign w_y_wrap  = (r_y == r_height - YW'(1));
  assign w_t_idx   = r_t[TIW-1:0];
  assign w_emit    = (r_y >= YW'(KERNEL - 1)) && (r_x >= XW'(KERNEL - 1)) && w_phase_ok;
  assign w_is_last = w_t_wrap && (r_x == r_last_x) && (r_y == r_last_y);

  // position of the image's final emitted window, fixed at load time
  always_comb begin
    w_new_last_x = i_width - XW'(1);
    w_new_last_y = i_height - YW'(1);
`ifdef WINDOW_STRIDE2_EN
    if (i_stride) begin
      w_new_last_x = XW'(KERNEL - 1) + ((i_width - XW'(KERNEL)) & ~XW'(1));
      w_new_last_y = YW'(KERNEL - 1) + ((i_height - YW'(KERNEL)) & ~YW'(1));
    end
`endif
  end

  // assemble the current column (line buffers + incoming word) and the full window
  always_comb begin
    w_col = '0;
    w_win = '0;
    for (int r = 0; r < KERNEL - 1; r++) begin
      w_col[r*WORD_WIDTH +: WORD_WIDTH] = r_line[KERNEL-2-r][r_addr];
    end
    w_col[(KERNEL-1)*WORD_WIDTH +: WORD_WIDTH] = i_data;
    for (int r = 0; r < KERNEL; r++) begin
      for (int c = 0; c < KERNEL - 1; c++) begin
        w_win[(r*KERNEL+c)*WORD_WIDTH +: WORD_WIDTH] = r_hist[KERNEL-2-c][w_t_idx][r*WORD_WIDTH +: WORD_WIDTH];
      end
      w_win[(r*KERNEL+KERNEL-1)*WORD_WIDTH +: WORD_WIDTH] = w_col[r*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  // geometry capture and raster counters
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_width  <= XW'(KERNEL);
      r_height <= YW'(KERNEL);
      r_trans  <= TW'(1);
      r_last_x <= XW'(KERNEL - 1);
      r_last_y <= YW'(KERNEL - 1);
      r_t      <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_addr   <= '0;
`ifdef WINDOW_STRIDE2_EN
      r_stride <= 1'b0;
`endif
    end else if (i_load_param) begin
      if (w_param_ok) begin
        r_width  <= i_width;
        r_height <= i_height;
        r_trans  <= i_transfers;
        r_last_x <= w_new_last_x;
        r_last_y <= w_new_last_y;
        r_t      <= '0;
        r_x      <= '0;
        r_y      <= '0;
        r_addr   <= '0;
`ifdef WINDOW_STRIDE2_EN
        r_stride <= i_stride;
`endif
      end
    end else if (w_accept) begin
      if (w_t_wrap) begin
        r_t <= '0;
        if (w_x_wrap) begin
          r_x    <= '0;
          r_addr <= '0;
          r_y    <= w_y_wrap ? '0 : r_y + YW'(1);
        end else begin
          r_x    <= r_x + XW'(1);
          r_addr <= r_addr + AW'(1);
        end
      end else begin
        r_t    <= r_t + TW'(1);
        r_addr <= r_addr + AW'(1);
      end
    end
  end

  // shift the accepted word down the line buffers and its column into the history
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_line[0][r_addr] <= i_data;
      for (int k = 1; k < KERNEL - 1; k++) begin
        r_line[k][r_addr] <= r_line[k-1][r_addr];
      end
      r_hist[0][w_t_idx] <= w_col;
      for (int j = 1; j < KERNEL - 1; j++) begin
        r_hist[j][w_t_idx] <= r_hist[j-1][w_t_idx];
      end
    end
  end

  // registered output beat with hold-under-backpressure
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_valid  <= 1'b0;
      r_window <= '0;
      r_last   <= 1'b0;
    end else if (i_load_param && w_param_ok) begin
      r_valid <= 1'b0;
    end else if (w_accept && w_emit) begin
      r_valid  <= 1'b1;
      r_window <= w_win;
      r_last   <= w_is_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_window_buffer_kxk.sv
// tb/tb_window_buffer_kxk.sv - scoreboard bench for window_buffer_kxk (K=3)
module tb_window_buffer_kxk;

  localparam int WW   = 8;
  localparam int K    = 3;
  localparam int WINW = K * K * WW;

  logic            i_clk;
  logic            i_reset_n;
  logic            i_load_param;
  logic [7:0]      i_width;
  logic [7:0]      i_height;
  logic [9:0]      i_transfers;
  logic            i_stride;
  logic            i_valid;
  logic            o_ready;
  logic [WW-1:0]   i_data;
  logic            o_valid;
  logic            i_ready;
  logic [WINW-1:0] o_window;
  logic            o_last_window;

  int total = 0;
  int bad   = 0;

  logic [WINW:0] exp_q[$];
  logic [WINW:0] obs_q[$];

  window_buffer_kxk #(
    .WORD_WIDTH(WW), .KERNEL(K), .MAX_IMG_WIDTH(128), .MAX_IMG_HEIGHT(128), .MAX_TRANSFERS(512)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_load_param(i_load_param),
    .i_width(i_width), .i_height(i_height), .i_transfers(i_transfers), .i_stride(i_stride),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_window(o_window), .o_last_window(o_last_window)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1);
  end

  // consume each beat the DUT hands downstream and compare against the scoreboard
  always @(negedge i_clk) begin : mon
    logic [WINW:0] e;
    if (i_reset_n && o_valid && i_ready) begin
      obs_q.push_back({o_last_window, o_window});
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_beat observed=%h required=none", {o_last_window, o_window});
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        assert ({o_last_window, o_window} === e) else begin
          bad++;
          $error("FAIL beat observed=%h required=%h", {o_last_window, o_window}, e);
        end
      end
    end
  end

  function automatic logic [WINW-1:0] w9(int a, int b, int c, int d, int e, int f, int g, int h, int i);
    return {8'(i), 8'(h), 8'(g), 8'(f), 8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [WINW-1:0] mkwin(int w, int tr, int y0, int x0, int tt);
    logic [WINW-1:0] v;
    v = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        v[(r*K+c)*WW +: WW] = WW'(((y0 + r) * w + (x0 + c)) * tr + tt);
    return v;
  endfunction

  // expected beats for one image whose word values are its raster index
  task automatic push_image(input int w, input int h, input int tr, input int s);
    logic [WINW:0] pend;
    bit have;
    have = 0;
    pend = '0;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        for (int t = 0; t < tr; t++)
          if (y >= K-1 && x >= K-1 && ((y-K+1) % s) == 0 && ((x-K+1) % s) == 0) begin
            if (have) exp_q.push_back(pend);
            pend = {1'b0, mkwin(w, tr, y-K+1, x-K+1, t)};
            have = 1;
          end
    if (have) begin
      pend[WINW] = 1'b1;
      exp_q.push_back(pend);
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s observed=%h required=%h", tag, obs, req);
    end
  endtask

  task automatic send_word(input logic [WW-1:0] d);
    int g;
    g = 0;
    i_valid = 1'b1;
    i_data  = d;
    @(negedge i_clk);
    while (!o_ready && g < 200) begin
      @(negedge i_clk);
      g++;
    end
    chk("send_timeout", 128'(g < 200), 128'(1));
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic stream(input int first, input int n);
    for (int i = 0; i < n; i++) send_word(WW'(first + i));
  endtask

  task automatic load(input int w, input int h, input int tr, input int s);
    i_load_param = 1'b1;
    i_width      = 8'(w);
    i_height     = 8'(h);
    i_transfers  = 10'(tr);
    i_stride     = s[0];
    @(negedge i_clk);
    chk("ready_during_load", 128'(o_ready), 128'(0));
    @(posedge i_clk);
    #1;
    i_load_param = 1'b0;
    i_stride     = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      @(negedge i_clk);
      g++;
    end
    @(negedge i_clk);
    chk("drain_left", 128'(exp_q.size()), 128'(0));
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_reset_values();
    @(negedge i_clk);
    chk("rst_valid", 128'(o_valid), 128'(0));
    chk("rst_window", 128'(o_window), 128'(0));
    chk("rst_last", 128'(o_last_window), 128'(0));
    chk("rst_ready", 128'(o_ready), 128'(1));
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_t1_obs(input string tag);
    chk({tag, "_count"}, 128'(obs_q.size()), 128'(4));
    if (obs_q.size() == 4) begin
      chk({tag, "_first"}, 128'(obs_q[0]), 128'({1'b0, w9(0, 1, 2, 4, 5, 6, 8, 9, 10)}));
      chk({tag, "_last"}, 128'(obs_q[3]), 128'({1'b1, w9(5, 6, 7, 9, 10, 11, 13, 14, 15)}));
    end
  endtask

  logic [WINW-1:0] hold;

  initial begin
    i_reset_n    = 1'b0;
    i_load_param = 1'b0;
    i_width      = '0;
    i_height     = '0;
    i_transfers  = '0;
    i_stride     = 1'b0;
    i_valid      = 1'b0;
    i_data       = '0;
    i_ready      = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    check_reset_values();

    // 4x4, T=1, with first-beat latency probes
    load(4, 4, 1, 0);
    obs_q.delete();
    push_image(4, 4, 1, 1);
    stream(0, 10);
    chk("t1_no_early_beat", 128'(o_valid), 128'(0));
    send_word(8'd10);
    chk("t1_latency_valid", 128'(o_valid), 128'(1));
    chk("t1_latency_window", 128'(o_window), 128'(w9(0, 1, 2, 4, 5, 6, 8, 9, 10)));
    stream(11, 5);
    drain();
    check_t1_obs("t1");

    // 3x3, T=2
    load(3, 3, 2, 0);
    obs_q.delete();
    push_image(3, 3, 2, 1);
    stream(0, 18);
    drain();
    chk("t2_count", 128'(obs_q.size()), 128'(2));
    if (obs_q.size() == 2) begin
      chk("t2_first", 128'(obs_q[0]), 128'({1'b0, w9(0, 2, 4, 6, 8, 10, 12, 14, 16)}));
      chk("t2_second", 128'(obs_q[1]), 128'({1'b1, w9(1, 3, 5, 7, 9, 11, 13, 15, 17)}));
    end

    // 4x4 with a 5-cycle stall after the first beat; second image streamed without reload
    load(4, 4, 1, 0);
    obs_q.delete();
    push_image(4, 4, 1, 1);
    push_image(4, 4, 1, 1);
    stream(0, 11);
    i_ready = 1'b0;
    hold    = o_window;
    chk("t3_hold_is_first", 128'(hold), 128'(w9(0, 1, 2, 4, 5, 6, 8, 9, 10)));
    i_valid = 1'b1;
    i_data  = 8'd11;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      chk("t3_stall_valid", 128'(o_valid), 128'(1));
      chk("t3_stall_ready", 128'(o_ready), 128'(0));
      chk("t3_stall_window", 128'(o_window), 128'(hold));
    end
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    stream(11, 5);
    stream(0, 16);
    drain();
    chk("t3_count", 128'(obs_q.size()), 128'(8));

    // reset in the middle of an image, then restream
    load(4, 4, 1, 0);
    stream(0, 8);
    i_reset_n = 1'b0;
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    check_reset_values();
    load(4, 4, 1, 0);
    obs_q.delete();
    push_image(4, 4, 1, 1);
    stream(0, 16);
    drain();
    check_t1_obs("t4");

    // out-of-range loads must be ignored
    load(4, 4, 1, 0);
    load(2, 4, 1, 0);
    load(4, 4, 0, 0);
    obs_q.delete();
    push_image(4, 4, 1, 1);
    stream(0, 16);
    drain();
    check_t1_obs("t5");

`ifdef WINDOW_STRIDE2_EN
    // 5x5 stride 2
    load(5, 5, 1, 1);
    obs_q.delete();
    push_image(5, 5, 1, 2);
    stream(0, 25);
    drain();
    chk("t6_count", 128'(obs_q.size()), 128'(4));
    if (obs_q.size() == 4) begin
      chk("t6_first", 128'(obs_q[0]), 128'({1'b0, w9(0, 1, 2, 5, 6, 7, 10, 11, 12)}));
      chk("t6_last", 128'(obs_q[3]), 128'({1'b1, w9(12, 13, 14, 17, 18, 19, 22, 23, 24)}));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
